// File: rtl/useq_pkg.sv
// Shared definitions for the microsequencer: sequencing opcodes, microword
// field layout helpers and stack fault causes.
package useq_pkg;

  typedef enum logic [2:0] {
    SEQ_NEXT     = 3'd0,
    SEQ_JUMP     = 3'd1,
    SEQ_BRT      = 3'd2,
    SEQ_BRF      = 3'd3,
    SEQ_CALL     = 3'd4,
    SEQ_RET      = 3'd5,
    SEQ_DISPATCH = 3'd6,
    SEQ_FETCH    = 3'd7
  } seq_op_t;

  localparam int unsigned SEQ_OP_W = 3;
  localparam int unsigned FSEL_LSB = SEQ_OP_W;

  localparam logic [1:0] FAULT_NONE      = 2'd0;
  localparam logic [1:0] FAULT_OVERFLOW  = 2'd1;
  localparam logic [1:0] FAULT_UNDERFLOW = 2'd2;

  // Flag-select width never drops below one bit, even for a single flag.
  function automatic int unsigned fsw_of(input int unsigned nflag);
    return (nflag > 2) ? int'($clog2(nflag)) : 1;
  endfunction

  function automatic int unsigned target_lsb(input int unsigned nflag);
    return SEQ_OP_W + fsw_of(nflag);
  endfunction

  function automatic int unsigned ctrl_lsb(input int unsigned uaw, input int unsigned nflag);
    return target_lsb(nflag) + uaw;
  endfunction

  function automatic int unsigned ctrl_w(input int unsigned uw, input int unsigned uaw,
                                         input int unsigned nflag);
    return uw - ctrl_lsb(uaw, nflag);
  endfunction

endpackage

// File: rtl/useq_stack.sv
// Micro-return LIFO: DEPTH entries of AW bits, asynchronously reset to empty.
module useq_stack import useq_pkg::*; #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] din,
  output logic [AW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [AW-1:0] mem [DEPTH];
  logic [CW-1:0] count;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = empty ? '0 : mem[IW'(count - 1'b1)];

  // Storage needs no reset; only the occupancy count defines validity.
  always_ff @(posedge clk) begin
    if (push && !full)
      mem[IW'(count)] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (push && !full)
      count <= count + 1'b1;
    else if (pop && !empty)
      count <= count - 1'b1;
  end

endmodule

// File: rtl/useq_engine.sv
// Microsequencer: opcode fetch, decode-map dispatch, flag branches and
// micro-subroutine call/return with sticky stack-fault detection.
module useq_engine import useq_pkg::*; #(
  parameter int unsigned UW         = 48,
  parameter int unsigned UAW        = 8,
  parameter int unsigned OPW        = 8,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned NFLAG      = 4,
  parameter logic [UAW-1:0] RESET_ADDR = '0,
  localparam int unsigned FSW       = fsw_of(NFLAG),
  localparam int unsigned CTRLW     = ctrl_w(UW, UAW, NFLAG)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic [OPW-1:0]   instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [NFLAG-1:0] flags,
  output logic [UAW-1:0]   ustore_addr,
  input  logic [UW-1:0]    ustore_data,
  output logic [OPW-1:0]   map_addr,
  input  logic [UAW-1:0]   map_data,
  output logic [OPW-1:0]   opcode_q,
  output logic [CTRLW-1:0] ctrl_out,
  output logic             eoi,
  output logic             err
);

  localparam int unsigned TLSB = target_lsb(NFLAG);
  localparam int unsigned CLSB = ctrl_lsb(UAW, NFLAG);

  logic [UAW-1:0] upc, upc_inc, upc_nxt, target, stk_top;
  logic [OPW-1:0] opc;
  logic           err_q;
  seq_op_t        op;
  logic [FSW-1:0] fsel;
  logic           flag_bit, active, take_fetch, push, pop;
  logic           stk_full, stk_empty;
  logic [1:0]     fault;

  assign op      = seq_op_t'(ustore_data[SEQ_OP_W-1:0]);
  assign fsel    = ustore_data[FSEL_LSB +: FSW];
  assign target  = ustore_data[TLSB +: UAW];
  assign upc_inc = upc + 1'b1;

  assign active     = !err_q && !stall;
  assign take_fetch = active && (op == SEQ_FETCH) && instr_valid;

  // Selects beyond the implemented flags read as zero.
  always_comb begin
    flag_bit = 1'b0;
    for (int unsigned i = 0; i < NFLAG; i++)
      if (fsel == FSW'(i)) flag_bit = flags[i];
  end

  always_comb begin
    upc_nxt = upc_inc;
    fault   = FAULT_NONE;
    unique case (op)
      SEQ_NEXT:     upc_nxt = upc_inc;
      SEQ_JUMP:     upc_nxt = target;
      SEQ_BRT:      upc_nxt = flag_bit ? target : upc_inc;
      SEQ_BRF:      upc_nxt = flag_bit ? upc_inc : target;
      SEQ_CALL: begin
        if (stk_full) fault = FAULT_OVERFLOW;
        else          upc_nxt = target;
      end
      SEQ_RET: begin
        if (stk_empty) fault = FAULT_UNDERFLOW;
        else           upc_nxt = stk_top;
      end
      SEQ_DISPATCH: upc_nxt = map_data;
      SEQ_FETCH:    upc_nxt = instr_valid ? upc_inc : upc;
    endcase
  end

  assign push = active && (op == SEQ_CALL) && (fault == FAULT_NONE);
  assign pop  = active && (op == SEQ_RET)  && (fault == FAULT_NONE);

  useq_stack #(.DEPTH(DEPTH), .AW(UAW)) u_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (upc_inc),
    .dout  (stk_top),
    .full  (stk_full),
    .empty (stk_empty)
  );

  // A faulting word leaves uPC in place; err then freezes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upc   <= RESET_ADDR;
      opc   <= '0;
      err_q <= 1'b0;
    end else if (active) begin
      if (fault != FAULT_NONE) err_q <= 1'b1;
      else                     upc   <= upc_nxt;
      if (take_fetch) opc <= instr;
    end
  end

  assign ustore_addr = upc;
  assign map_addr    = opc;
  assign opcode_q    = opc;
  assign err         = err_q;
  assign instr_ready = take_fetch;
  assign eoi         = take_fetch;
  assign ctrl_out    = (stall || err_q || ((op == SEQ_FETCH) && !instr_valid))
                       ? '0 : ustore_data[CLSB +: CTRLW];

endmodule

// File: tb/tb_useq_engine.sv
// Directed and randomized checks of useq_engine against a queue-based
// behavioural model of the microsequencer rules.
module tb_useq_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall = 1'b0;
  logic [7:0]  instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [3:0]  flags = '0;
  logic [7:0]  ustore_addr;
  logic [47:0] ustore_data;
  logic [7:0]  map_addr;
  logic [7:0]  map_data;
  logic [7:0]  opcode_q;
  logic [34:0] ctrl_out;
  logic        eoi;
  logic        err;

  logic [47:0] ustore [256];
  logic [7:0]  dmap [256];

  assign ustore_data = ustore[ustore_addr];
  assign map_data    = dmap[map_addr];

  useq_engine #(.UW(48), .UAW(8), .OPW(8), .DEPTH(4), .NFLAG(4), .RESET_ADDR(8'h00)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .flags       (flags),
    .ustore_addr (ustore_addr),
    .ustore_data (ustore_data),
    .map_addr    (map_addr),
    .map_data    (map_data),
    .opcode_q    (opcode_q),
    .ctrl_out    (ctrl_out),
    .eoi         (eoi),
    .err         (err)
  );

  always #5 clk = ~clk;

  int unsigned pass_cnt = 0;
  int unsigned total    = 0;

  // Reference state
  logic [7:0] m_upc;
  logic [7:0] m_opc;
  logic       m_err;
  logic [7:0] m_stk [$];

  function automatic logic [47:0] mkw(input logic [2:0] op, input logic [1:0] fs,
                                      input logic [7:0] tgt, input logic [34:0] c);
    return {c, tgt, fs, op};
  endfunction

  function automatic logic [34:0] rnd_ctrl();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[34:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clear_store();
    for (int a = 0; a < 256; a++) begin
      ustore[a] = mkw(3'd0, 2'd0, 8'h00, rnd_ctrl());
      dmap[a]   = 8'(a);
    end
  endtask

  // Apply the sequencing rules for one clock edge using the current inputs.
  task automatic model_step(input logic [47:0] w);
    logic [2:0] op;
    logic [1:0] fs;
    logic [7:0] tgt;
    logic       f;
    op  = w[2:0];
    fs  = w[4:3];
    tgt = w[12:5];
    f   = (int'(fs) < 4) ? flags[fs] : 1'b0;
    if (m_err || stall) return;
    case (op)
      3'd0: m_upc = m_upc + 8'd1;
      3'd1: m_upc = tgt;
      3'd2: m_upc = f ? tgt : m_upc + 8'd1;
      3'd3: m_upc = f ? m_upc + 8'd1 : tgt;
      3'd4: if (m_stk.size() == 4) m_err = 1'b1;
            else begin m_stk.push_back(m_upc + 8'd1); m_upc = tgt; end
      3'd5: if (m_stk.size() == 0) m_err = 1'b1;
            else m_upc = m_stk.pop_back();
      3'd6: m_upc = dmap[m_opc];
      default: if (instr_valid) begin m_opc = instr; m_upc = m_upc + 8'd1; end
    endcase
  endtask

  task automatic cycle();
    logic [47:0] w;
    logic [2:0]  op;
    logic        rdy;
    logic [34:0] ec;
    #1;
    w   = ustore[m_upc];
    op  = w[2:0];
    rdy = (op == 3'd7) && instr_valid && !stall && !m_err;
    ec  = (stall || m_err || (op == 3'd7 && !instr_valid)) ? 35'd0 : w[47:13];
    chk("ustore_addr", 64'(ustore_addr), 64'(m_upc));
    chk("map_addr",    64'(map_addr),    64'(m_opc));
    chk("opcode_q",    64'(opcode_q),    64'(m_opc));
    chk("instr_ready", 64'(instr_ready), 64'(rdy));
    chk("eoi",         64'(eoi),         64'(rdy));
    chk("ctrl_out",    64'(ctrl_out),    64'(ec));
    chk("err",         64'(err),         64'(m_err));
    model_step(w);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_upc", 64'(ustore_addr), 64'h00);
    chk("rst_err", 64'(err),         64'h0);
    chk("rst_opc", 64'(opcode_q),    64'h00);
    m_upc = 8'h00;
    m_opc = 8'h00;
    m_err = 1'b0;
    m_stk.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] rets [4];
    logic [7:0] exp_br;

    // Fetch, then dispatch through the decode map
    clear_store();
    ustore[8'h00] = mkw(3'd7, 2'd0, 8'h00, 35'h1234);
    ustore[8'h01] = mkw(3'd6, 2'd0, 8'h00, 35'h777);
    ustore[8'h40] = mkw(3'd0, 2'd0, 8'h00, 35'h5AA5A55A);
    dmap[8'h5A]   = 8'h40;
    instr = 8'h5A;
    do_reset();
    cycle();
    cycle();
    chk("fetch_idle_addr",  64'(ustore_addr), 64'h00);
    chk("fetch_idle_ctrl",  64'(ctrl_out),    64'h0);
    chk("fetch_idle_ready", 64'(instr_ready), 64'h0);
    instr_valid = 1'b1;
    #1;
    chk("fetch_eoi", 64'(eoi), 64'h1);
    cycle();
    instr_valid = 1'b0;
    #1;
    chk("fetch_opcode", 64'(opcode_q),    64'h5A);
    chk("fetch_upc",    64'(ustore_addr), 64'h01);
    chk("fetch_eoi_end", 64'(eoi),        64'h0);
    cycle();
    chk("dispatch_upc",  64'(ustore_addr), 64'h40);
    chk("dispatch_ctrl", 64'(ctrl_out),    64'h5AA5A55A);
    cycle();

    // BRT / BRF on flag 2, taken and not taken
    for (int k = 0; k < 4; k++) begin
      clear_store();
      ustore[8'h00] = mkw(3'd1, 2'd0, 8'h50, 35'h1);
      ustore[8'h50] = mkw((k < 2) ? 3'd2 : 3'd3, 2'd2, 8'h80, 35'h2);
      flags = (k % 2 == 0) ? 4'b0100 : 4'b0000;
      if (k < 2) exp_br = (k == 0) ? 8'h80 : 8'h51;
      else       exp_br = (k == 2) ? 8'h51 : 8'h80;
      do_reset();
      cycle();
      cycle();
      chk("branch_target", 64'(ustore_addr), 64'(exp_br));
    end
    flags = '0;

    // Four nested CALLs unwound by four RETs
    clear_store();
    ustore[8'h00] = mkw(3'd1, 2'd0, 8'h10, 35'h0);
    ustore[8'h10] = mkw(3'd4, 2'd0, 8'h20, 35'h10);
    ustore[8'h20] = mkw(3'd4, 2'd0, 8'h30, 35'h20);
    ustore[8'h30] = mkw(3'd4, 2'd0, 8'h40, 35'h30);
    ustore[8'h40] = mkw(3'd4, 2'd0, 8'h50, 35'h40);
    ustore[8'h50] = mkw(3'd5, 2'd0, 8'h00, 35'h50);
    ustore[8'h41] = mkw(3'd5, 2'd0, 8'h00, 35'h41);
    ustore[8'h31] = mkw(3'd5, 2'd0, 8'h00, 35'h31);
    ustore[8'h21] = mkw(3'd5, 2'd0, 8'h00, 35'h21);
    rets = '{8'h41, 8'h31, 8'h21, 8'h11};
    do_reset();
    repeat (5) cycle();
    chk("call_depth4_upc", 64'(ustore_addr), 64'h50);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("ret_addr", 64'(ustore_addr), 64'(rets[i]));
    end

    // Fifth CALL overflows the stack
    ustore[8'h50] = mkw(3'd4, 2'd0, 8'h60, 35'h5555);
    do_reset();
    repeat (5) cycle();
    cycle();
    chk("ovf_err",  64'(err),         64'h1);
    chk("ovf_upc",  64'(ustore_addr), 64'h50);
    chk("ovf_ctrl", 64'(ctrl_out),    64'h0);
    repeat (3) cycle();
    chk("ovf_sticky", 64'(err), 64'h1);

    // RET on an empty stack
    clear_store();
    ustore[8'h00] = mkw(3'd5, 2'd0, 8'h00, 35'h9);
    do_reset();
    cycle();
    chk("unf_err", 64'(err),         64'h1);
    chk("unf_upc", 64'(ustore_addr), 64'h00);

    // NEXT wraps from 0xFF to 0x00
    clear_store();
    ustore[8'h00] = mkw(3'd1, 2'd0, 8'hFF, 35'h0);
    do_reset();
    cycle();
    cycle();
    chk("wrap_upc", 64'(ustore_addr), 64'h00);

    // Stalled CALL must not push; exactly one entry after it proceeds
    clear_store();
    ustore[8'h00] = mkw(3'd4, 2'd0, 8'h20, 35'hABC);
    ustore[8'h20] = mkw(3'd5, 2'd0, 8'h00, 35'h1);
    ustore[8'h01] = mkw(3'd5, 2'd0, 8'h00, 35'h2);
    do_reset();
    stall = 1'b1;
    cycle();
    cycle();
    chk("stall_upc",  64'(ustore_addr), 64'h00);
    chk("stall_ctrl", 64'(ctrl_out),    64'h0);
    stall = 1'b0;
    cycle();
    cycle();
    cycle();
    chk("stall_single_push", 64'(err), 64'h1);

    // Reset pulsed in the middle of a stalled CALL
    do_reset();
    stall = 1'b1;
    cycle();
    do_reset();
    ustore[8'h00] = mkw(3'd5, 2'd0, 8'h00, 35'h3);
    stall = 1'b0;
    #1;
    chk("midstall_rst_upc", 64'(ustore_addr), 64'h00);
    cycle();
    chk("midstall_rst_empty", 64'(err), 64'h1);

    // Randomized microprograms against the model
    for (int r = 0; r < 6; r++) begin
      for (int a = 0; a < 256; a++) begin
        ustore[a] = mkw(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                        8'($urandom), rnd_ctrl());
        dmap[a]   = 8'($urandom);
      end
      stall = 1'b0;
      instr_valid = 1'b0;
      do_reset();
      for (int c = 0; c < 120; c++) begin
        flags       = 4'($urandom);
        instr       = 8'($urandom);
        instr_valid = 1'($urandom_range(0, 1));
        stall       = ($urandom_range(0, 7) == 0);
        cycle();
        if (m_err && $urandom_range(0, 3) == 0) do_reset();
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/useq_engine.md
# useq_engine

Parametrised microsequencer, next generation of the 8-bit CPU control unit. It fetches opcodes, dispatches through an external decode map and steps an external microstore. It adds conditional branches on datapath flags, micro-subroutine CALL/RET with a hardware return stack, an external stall and sticky error detection. It sits between the instruction buffer/decode ROM and the datapath control lines.

## Interface
Parameters:
- UW, 48, microword width
- UAW, 8, micro-address width
- OPW, 8, opcode width
- DEPTH, 4, return-stack entries (≥1)
- NFLAG, 4, flag inputs; FSW = max(1, clog2(NFLAG))
- RESET_ADDR, 0, uPC value after reset

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  freeze all state this cycle
- instr  in  OPW  opcode from instruction buffer
- instr_valid  in  1  opcode available
- instr_ready  out  1  opcode accepted this cycle
- flags  in  NFLAG  datapath condition flags
- ustore_addr  out  UAW  microstore address (= uPC)
- ustore_data  in  UW  microword, combinational read of ustore_addr
- map_addr  out  OPW  decode-map address (= opcode_q)
- map_data  in  UAW  dispatch target, combinational
- opcode_q  out  OPW  latched opcode (register/ALU select fields)
- ctrl_out  out  UW-3-FSW-UAW  datapath control field
- eoi  out  1  instruction boundary pulse
- err  out  1  sticky stack fault

## Operation
- Microword fields, LSB first: seq_op[2:0], fsel[FSW-1:0], target[UAW-1:0], ctrl (remaining bits).
- The microword at uPC executes in the cycle uPC holds it. uPC+1 wraps modulo 2^UAW.
- seq_op encodings and next-uPC rules:
  - 0 NEXT: uPC+1.
  - 1 JUMP: target.
  - 2 BRT: target if flags[fsel]=1, else uPC+1.
  - 3 BRF: target if flags[fsel]=0, else uPC+1.
  - 4 CALL: push uPC+1, then target.
  - 5 RET: pop.
  - 6 DISPATCH: map_data.
  - 7 FETCH: if instr_valid, latch opcode_q ← instr and go to uPC+1; otherwise hold uPC.
- fsel ≥ NFLAG reads the flag as 0.
- instr_ready = FETCH & instr_valid & !stall & !err. It is combinational.
- eoi = instr_ready. It is a single-cycle pulse per accepted opcode.
- ctrl_out = ctrl field, forced to 0 in any of these cases: stall, err, or FETCH without instr_valid.
- Stack faults:
  - CALL with DEPTH entries already stacked → err.
  - RET with an empty stack → err.
  - On a fault, uPC and the stack are unchanged.
  - err is sticky until reset; while it is set, uPC is frozen and no outputs other than err are asserted.
- Priority: rst_n > err > stall > seq_op.
- Reset values: uPC=RESET_ADDR, stack empty, opcode_q=0, err=0. Therefore ustore_addr=RESET_ADDR and map_addr=0. ctrl_out, instr_ready and eoi follow combinationally from the microword.

## Timing
- Next-address latency is one cycle. uPC updates on the edge that ends the executing word.
- FETCH then DISPATCH: the opcode is accepted in cycle n. opcode_q is valid from n+1, so a DISPATCH at uPC+1 in cycle n+1 sees the new map_data. The earliest handler word executes in n+2.
- CALL and RET each take one cycle. A RET directly after a CALL returns to CALL-address+1.
- Simultaneous CALL-push and stall: stall wins, and no push occurs.
- Async reset mid-instruction clears immediately. The first word after deassertion executes at RESET_ADDR on the next edge.
- No combinational path from ctrl_out back to the inputs. Flag-to-uPC is a single register stage.

## Structure
- Package useq_pkg holds:
  - the seq_op enum (NEXT…FETCH);
  - field offset/width functions of (UW, UAW, NFLAG);
  - the fault-cause localparams.
- Sub-module useq_stack: a LIFO of DEPTH×UAW with push, pop, full and empty, and an async reset to empty.
- Microstore and decode map stay external ROMs, one per target, unchanged from the current generation.

## Test plan
- Reset with RESET_ADDR=0 and word 0 = FETCH, instr_valid=0. Required: ustore_addr holds 0, ctrl_out=0, instr_ready=0. Then raise instr_valid with instr=0x5A. Required: eoi=1 for one cycle, opcode_q=0x5A, and uPC goes to 1.
- Word 1 = DISPATCH with map_data=0x40. Required: uPC=0x40 next cycle, and the ctrl field of word 0x40 appears on ctrl_out.
- BRT fsel=2: with flags=4'b0100, uPC jumps to target 0x80. With flags=0, uPC goes to uPC+1. Repeat for BRF with the inverse results.
- Nested CALLs with DEPTH=4:
  - four CALLs from 0x10, 0x20, 0x30, 0x40, then four RETs return 0x41, 0x31, 0x21, 0x11;
  - a fifth CALL sets err, freezes uPC and sets ctrl_out=0;
  - err holds until rst_n is asserted low.
- RET at an empty stack sets err. Separately, a NEXT at uPC=0xFF wraps to 0x00.
- Stall asserted during CALL, then rst_n pulsed low mid-stall. Required: no push occurs while stalled, and after reset the stack is empty and uPC=RESET_ADDR.
